// File: rtl/tow_pkg.sv
// -----------------------------------------------------------------------------
// tow_pkg
// Shared definitions for the tug-of-war scoring datapath.
//   - led_control encodings driven by the master controller
//   - winner encodings reported on the winner output
//   - play-mode enumeration decoded from led_control/clear
//   - helpers for the centre and end indices of the LED bar
// -----------------------------------------------------------------------------
package tow_pkg;

    // led_control encodings from the master controller (01 is reserved)
    localparam logic [1:0] LC_ALL  = 2'b11;
    localparam logic [1:0] LC_POS  = 2'b10;
    localparam logic [1:0] LC_DARK = 2'b00;

    // winner encodings
    localparam logic WINNER_L = 1'b0;
    localparam logic WINNER_R = 1'b1;

    // Operating mode, decoded every cycle from the controller outputs
    typedef enum logic [1:0] {
        MODE_WAIT  = 2'd0,
        MODE_DARK  = 2'd1,
        MODE_PLAY  = 2'd2,
        MODE_GLOAT = 2'd3
    } mode_e;

    // Centre index of an odd-length bar
    function automatic int centre_idx(input int n_leds);
        return (n_leds - 1) / 2;
    endfunction

    // Index of the leftmost LED (the left player's goal)
    function automatic int end_idx(input int n_leds);
        return n_leds - 1;
    endfunction

    // Any combination that is not one of the three named modes is
    // treated as WAIT, so the rope is held at the centre by default.
    function automatic mode_e decode_mode(input logic [1:0] led_control,
                                          input logic       clear);
        mode_e mode;
        mode = MODE_WAIT;
        if (led_control == LC_DARK && !clear) begin
            mode = MODE_DARK;
        end else if (led_control == LC_POS && !clear) begin
            mode = MODE_PLAY;
        end else if (led_control == LC_POS && clear) begin
            mode = MODE_GLOAT;
        end
        return mode;
    endfunction

endpackage

// File: rtl/tow_press_edge.sv
// -----------------------------------------------------------------------------
// tow_press_edge
// Converts a synchronised, debounced button level into a single-cycle press
// pulse on each rising edge. Holding the button never repeats the pulse.
//
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset (clears the history register)
//   btn    in   button level
//   press  out  high for the cycle in which btn is 1 and was 0 last cycle
// -----------------------------------------------------------------------------
module tow_press_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic btn_q;
    logic btn_d;

    always_comb begin
        btn_d = btn;
        press = btn & ~btn_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= 1'b0;
        end else begin
            btn_q <= btn_d;
        end
    end

endmodule

// File: rtl/tow_scorer.sv
// -----------------------------------------------------------------------------
// tow_scorer
// Rope-position and scoring datapath downstream of the tug-of-war master
// controller. Tracks the rope, drives the LED bar, detects round wins and
// false starts, and returns the one-cycle winrnd pulse to the controller.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   clear        in   1 = presses ignored and rope frozen
//   leds_on      in   0 forces the bar dark
//   led_control  in   11 all on, 10 show position, 00 dark, 01 reserved
//   pbl, pbr     in   left/right player buttons (debounced levels)
//   leds         out  bar drive, leds[N_LEDS-1] is leftmost
//   winrnd       out  one-cycle pulse when a round is decided
//   winner       out  0 = left, 1 = right; valid from winrnd until re-centre
//   score_l/_r   out  saturating round-win counters
// -----------------------------------------------------------------------------
module tow_scorer
    import tow_pkg::*;
#(
    parameter int N_LEDS  = 7,
    parameter int SCORE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               leds_on,
    input  logic [1:0]         led_control,
    input  logic               pbl,
    input  logic               pbr,
    output logic [N_LEDS-1:0]  leds,
    output logic               winrnd,
    output logic               winner,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r
);

    localparam int POS_W = $clog2(N_LEDS);

    localparam logic [POS_W-1:0]   POS_C     = POS_W'(centre_idx(N_LEDS));
    localparam logic [POS_W-1:0]   POS_END   = POS_W'(end_idx(N_LEDS));
    localparam logic [POS_W-1:0]   POS_ZERO  = '0;
    localparam logic [POS_W-1:0]   POS_PRE_L = POS_W'(end_idx(N_LEDS) - 1);
    localparam logic [POS_W-1:0]   POS_PRE_R = POS_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    logic               press_l;
    logic               press_r;
    mode_e              mode;
    logic               dark_entry;
    logic               win_l;
    logic               win_r;
    logic [N_LEDS-1:0]  pos_onehot;

    logic [POS_W-1:0]   pos_q,     pos_d;
    logic               won_q,     won_d;
    logic               winrnd_q,  winrnd_d;
    logic               winner_q,  winner_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d;
    logic [SCORE_W-1:0] score_r_q, score_r_d;
    logic [N_LEDS-1:0]  leds_q,    leds_d;
    logic               clear_q,   clear_d;

    tow_press_edge u_edge_l (
        .clk   (clk),
        .rst   (rst),
        .btn   (pbl),
        .press (press_l)
    );

    tow_press_edge u_edge_r (
        .clk   (clk),
        .rst   (rst),
        .btn   (pbr),
        .press (press_r)
    );

    // Rope and scoring next-state. Re-centring (WAIT, or the falling edge of
    // clear that marks entry to Dark) has priority over any press in the
    // same cycle. Once a round is won the rope stays at the winner's end
    // until the next re-centre, which is what the bar shows while gloating.
    always_comb begin
        pos_d      = pos_q;
        won_d      = won_q;
        winrnd_d   = 1'b0;
        winner_d   = winner_q;
        score_l_d  = score_l_q;
        score_r_d  = score_r_q;
        clear_d    = clear;
        win_l      = 1'b0;
        win_r      = 1'b0;
        mode       = decode_mode(led_control, clear);
        dark_entry = !clear && clear_q;

        if (mode == MODE_WAIT || dark_entry) begin
            pos_d = POS_C;
            won_d = 1'b0;
        end else if (!won_q) begin
            case (mode)
                MODE_PLAY: begin
                    if (press_l && !press_r) begin
                        pos_d = pos_q + 1'b1;
                        win_l = (pos_q == POS_PRE_L);
                    end else if (press_r && !press_l) begin
                        pos_d = pos_q - 1'b1;
                        win_r = (pos_q == POS_PRE_R);
                    end
                end
                // A press while the bar is dark is a false start and hands
                // the round to the opponent outright.
                MODE_DARK: begin
                    if (press_l && !press_r) begin
                        pos_d = POS_ZERO;
                        win_r = 1'b1;
                    end else if (press_r && !press_l) begin
                        pos_d = POS_END;
                        win_l = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end

        if (win_l) begin
            won_d    = 1'b1;
            winner_d = WINNER_L;
            winrnd_d = 1'b1;
            if (score_l_q != SCORE_MAX) begin
                score_l_d = score_l_q + 1'b1;
            end
        end

        if (win_r) begin
            won_d    = 1'b1;
            winner_d = WINNER_R;
            winrnd_d = 1'b1;
            if (score_r_q != SCORE_MAX) begin
                score_r_d = score_r_q + 1'b1;
            end
        end
    end

    // The bar is registered from the current rope position, so it shows a
    // new position one cycle after the press that caused it.
    always_comb begin
        pos_onehot = {{(N_LEDS-1){1'b0}}, 1'b1} << pos_q;
        leds_d     = '0;
        if (leds_on) begin
            case (led_control)
                LC_ALL:  leds_d = '1;
                LC_POS:  leds_d = pos_onehot;
                default: leds_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q     <= POS_C;
            won_q     <= 1'b0;
            winrnd_q  <= 1'b0;
            winner_q  <= WINNER_L;
            score_l_q <= '0;
            score_r_q <= '0;
            leds_q    <= '0;
            clear_q   <= 1'b0;
        end else begin
            pos_q     <= pos_d;
            won_q     <= won_d;
            winrnd_q  <= winrnd_d;
            winner_q  <= winner_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            leds_q    <= leds_d;
            clear_q   <= clear_d;
        end
    end

    assign leds    = leds_q;
    assign winrnd  = winrnd_q;
    assign winner  = winner_q;
    assign score_l = score_l_q;
    assign score_r = score_r_q;

endmodule

// File: tb/tb_tow_scorer.sv
// Self-checking bench for tow_scorer (N_LEDS=7, SCORE_W=4).
// A behavioural model predicts the outputs for every driven cycle; the
// predictions are queued and compared after the following clock edge.
module tb_tow_scorer;

   localparam int N  = 7;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          clear;
   logic          leds_on;
   logic [1:0]    led_control;
   logic          pbl;
   logic          pbr;
   logic [N-1:0]  leds;
   logic          winrnd;
   logic          winner;
   logic [SW-1:0] score_l;
   logic [SW-1:0] score_r;

   typedef struct packed {
      logic [N-1:0]  leds;
      logic          winrnd;
      logic          winner;
      logic [SW-1:0] score_l;
      logic [SW-1:0] score_r;
   } expect_t;

   expect_t scoreQ[$];

   int errCount   = 0;
   int checkCount = 0;

   // Model state
   int       mPos = 3;
   bit       mWon, mWinrnd, mWinner;
   int       mScoreL, mScoreR;
   logic [N-1:0] mLeds;
   bit       mPblPrev, mPbrPrev, mClearPrev;

   always #5 clk = ~clk;

   tow_scorer #(.N_LEDS(N), .SCORE_W(SW)) dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .leds_on     (leds_on),
      .led_control (led_control),
      .pbl         (pbl),
      .pbr         (pbr),
      .leds        (leds),
      .winrnd      (winrnd),
      .winner      (winner),
      .score_l     (score_l),
      .score_r     (score_r)
   );

   // Single comparison point: counts and reports
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   // Round award in the model
   task automatic awardWin(input bit toRight);
      mWon    = 1'b1;
      mWinner = toRight;
      mWinrnd = 1'b1;
      if (toRight) mScoreR = (mScoreR < 15) ? mScoreR + 1 : 15;
      else         mScoreL = (mScoreL < 15) ? mScoreL + 1 : 15;
   endtask

   // Behavioural model of one clock edge with the given inputs
   task automatic modelStep(input logic r, input logic c, input logic on,
                            input logic [1:0] lc, input logic l, input logic pr);
      bit pressL, pressR, isWait;
      if (r) begin
         mPos = 3; mWon = 0; mWinrnd = 0; mWinner = 0;
         mScoreL = 0; mScoreR = 0; mLeds = '0;
         mPblPrev = 0; mPbrPrev = 0; mClearPrev = 0;
      end else begin
         pressL = l && !mPblPrev;
         pressR = pr && !mPbrPrev;
         if (!on || lc == 2'b00 || lc == 2'b01) mLeds = '0;
         else if (lc == 2'b11)                  mLeds = '1;
         else                                   mLeds = N'(1 << mPos);
         mWinrnd = 0;
         isWait = !((lc == 2'b10) || (lc == 2'b00 && !c));
         if (isWait || (!c && mClearPrev)) begin
            mPos = 3;
            mWon = 0;
         end else if (!mWon && !c && pressL != pressR) begin
            if (lc == 2'b10) begin
               mPos = pressL ? mPos + 1 : mPos - 1;
               if (mPos == N - 1) awardWin(1'b0);
               else if (mPos == 0) awardWin(1'b1);
            end else begin
               if (pressL) begin mPos = 0;     awardWin(1'b1); end
               else        begin mPos = N - 1; awardWin(1'b0); end
            end
         end
         mPblPrev   = l;
         mPbrPrev   = pr;
         mClearPrev = c;
      end
   endtask

   // Drive one cycle, queue the prediction, compare after the edge
   task automatic applyStimulus(input logic r, input logic c, input logic on,
                                input logic [1:0] lc, input logic l, input logic pr);
      expect_t e;
      expect_t got;
      @(negedge clk);
      rst = r; clear = c; leds_on = on; led_control = lc; pbl = l; pbr = pr;
      modelStep(r, c, on, lc, l, pr);
      e.leds = mLeds; e.winrnd = mWinrnd; e.winner = mWinner;
      e.score_l = SW'(mScoreL); e.score_r = SW'(mScoreR);
      scoreQ.push_back(e);
      @(posedge clk);
      #1;
      if (scoreQ.size() > 0) begin
         got = scoreQ.pop_front();
         checkOutput("sb_leds",    32'(leds),    32'(got.leds));
         checkOutput("sb_winrnd",  32'(winrnd),  32'(got.winrnd));
         checkOutput("sb_winner",  32'(winner),  32'(got.winner));
         checkOutput("sb_score_l", 32'(score_l), 32'(got.score_l));
         checkOutput("sb_score_r", 32'(score_r), 32'(got.score_r));
      end
   endtask

   initial begin
      rst = 1'b1; clear = 1'b1; leds_on = 1'b1; led_control = 2'b11; pbl = 1'b1; pbr = 1'b0;

      // 1: reset with pbl held, then WAIT
      applyStimulus(1, 1, 1, 2'b11, 1, 0);
      applyStimulus(1, 1, 1, 2'b11, 1, 0);
      checkOutput("t1_reset_leds", 32'(leds), 32'h0);
      applyStimulus(0, 1, 1, 2'b11, 1, 0);
      applyStimulus(0, 1, 1, 2'b11, 0, 0);
      applyStimulus(0, 1, 1, 2'b11, 0, 0);
      checkOutput("t1_leds_all", 32'(leds),    32'h7F);
      checkOutput("t1_score_l",  32'(score_l), 32'h0);
      checkOutput("t1_score_r",  32'(score_r), 32'h0);

      // 2: Dark entry, then three left presses in PLAY
      applyStimulus(0, 1, 1, 2'b00, 0, 0);
      applyStimulus(0, 0, 1, 2'b00, 0, 0);
      applyStimulus(0, 0, 1, 2'b10, 1, 0);
      applyStimulus(0, 0, 1, 2'b10, 0, 0);
      applyStimulus(0, 0, 1, 2'b10, 1, 0);
      applyStimulus(0, 0, 1, 2'b10, 0, 0);
      checkOutput("t2_leds_pos5", 32'(leds), 32'h20);
      applyStimulus(0, 0, 1, 2'b10, 1, 0);
      checkOutput("t2_winrnd",  32'(winrnd),  32'h1);
      checkOutput("t2_winner",  32'(winner),  32'h0);
      checkOutput("t2_score_l", 32'(score_l), 32'h1);
      applyStimulus(0, 0, 1, 2'b10, 0, 0);
      checkOutput("t2_winrnd_low", 32'(winrnd), 32'h0);
      checkOutput("t2_leds_end",   32'(leds),   32'h40);

      // 3: false start in DARK by the right player
      applyStimulus(0, 1, 1, 2'b10, 0, 0);
      applyStimulus(0, 1, 1, 2'b00, 0, 0);
      applyStimulus(0, 0, 1, 2'b00, 0, 0);
      applyStimulus(0, 0, 1, 2'b00, 0, 1);
      checkOutput("t3_winrnd",  32'(winrnd),  32'h1);
      checkOutput("t3_winner",  32'(winner),  32'h0);
      checkOutput("t3_score_l", 32'(score_l), 32'h2);
      applyStimulus(0, 0, 1, 2'b00, 0, 0);
      applyStimulus(0, 0, 1, 2'b00, 0, 1);
      checkOutput("t3_second_winrnd",  32'(winrnd),  32'h0);
      checkOutput("t3_second_score_l", 32'(score_l), 32'h2);
      applyStimulus(0, 0, 1, 2'b00, 0, 0);
      applyStimulus(0, 1, 1, 2'b10, 0, 0);
      checkOutput("t3_leds_left_end", 32'(leds), 32'h40);

      // 4: simultaneous presses, then a long hold
      applyStimulus(0, 1, 1, 2'b11, 0, 0);
      applyStimulus(0, 0, 1, 2'b10, 0, 0);
      applyStimulus(0, 0, 1, 2'b10, 1, 1);
      checkOutput("t4_both_winrnd", 32'(winrnd), 32'h0);
      applyStimulus(0, 0, 1, 2'b10, 0, 0);
      checkOutput("t4_both_leds", 32'(leds), 32'h08);
      for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 2'b10, 1, 0);
      applyStimulus(0, 0, 1, 2'b10, 0, 0);
      checkOutput("t4_hold_leds", 32'(leds), 32'h10);

      // 5: GLOAT freezes the rope; clear falling re-centres over a press
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 1, 2'b10, 1, 0);
         applyStimulus(0, 1, 1, 2'b10, 0, 1);
      end
      applyStimulus(0, 1, 1, 2'b10, 0, 0);
      checkOutput("t5_gloat_leds", 32'(leds), 32'h10);
      applyStimulus(0, 0, 1, 2'b10, 1, 0);
      applyStimulus(0, 0, 1, 2'b10, 0, 0);
      checkOutput("t5_recentre_leds", 32'(leds), 32'h08);

      // Right player wins in PLAY
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 1, 2'b10, 0, 1);
         if (i == 2) begin
            checkOutput("tr_winrnd",  32'(winrnd),  32'h1);
            checkOutput("tr_winner",  32'(winner),  32'h1);
            checkOutput("tr_score_r", 32'(score_r), 32'h1);
         end
         applyStimulus(0, 0, 1, 2'b10, 0, 0);
      end
      checkOutput("tr_leds_right_end", 32'(leds), 32'h01);

      // 6: saturate score_r via false starts by the left player
      for (int i = 0; i < 14; i++) begin
         applyStimulus(0, 1, 1, 2'b00, 0, 0);
         applyStimulus(0, 0, 1, 2'b00, 0, 0);
         applyStimulus(0, 0, 1, 2'b00, 1, 0);
         applyStimulus(0, 0, 1, 2'b00, 0, 0);
      end
      checkOutput("t6_score_r_max", 32'(score_r), 32'hF);
      applyStimulus(0, 1, 1, 2'b00, 0, 0);
      applyStimulus(0, 0, 1, 2'b00, 0, 0);
      applyStimulus(0, 0, 1, 2'b00, 1, 0);
      checkOutput("t6_sat_winrnd",  32'(winrnd),  32'h1);
      checkOutput("t6_sat_score_r", 32'(score_r), 32'hF);
      applyStimulus(0, 0, 1, 2'b00, 0, 0);

      // Reset in the middle of a round
      applyStimulus(0, 1, 1, 2'b11, 0, 0);
      applyStimulus(0, 0, 1, 2'b10, 0, 0);
      applyStimulus(0, 0, 1, 2'b10, 1, 0);
      applyStimulus(0, 0, 1, 2'b10, 0, 0);
      applyStimulus(0, 0, 1, 2'b10, 1, 0);
      applyStimulus(0, 0, 1, 2'b10, 0, 0);
      checkOutput("t6_pre_reset_leds", 32'(leds), 32'h20);
      applyStimulus(1, 0, 1, 2'b10, 0, 0);
      checkOutput("t6_rst_leds",    32'(leds),    32'h0);
      checkOutput("t6_rst_score_l", 32'(score_l), 32'h0);
      checkOutput("t6_rst_score_r", 32'(score_r), 32'h0);
      checkOutput("t6_rst_winrnd",  32'(winrnd),  32'h0);
      applyStimulus(0, 0, 1, 2'b10, 0, 0);
      checkOutput("t6_post_rst_leds", 32'(leds), 32'h08);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
